// File: rtl/friscv_inst_prefetch.sv
// Instruction prefetch unit: runs ahead of decode with a single outstanding memory
// request and buffers up to DEPTH {pc, instruction} pairs. Redirects drop buffered and in-flight data.
module friscv_inst_prefetch #(
  parameter int                    INST_ADDRW = 16,
  parameter logic [INST_ADDRW-1:0] BOOT_ADDR  = {INST_ADDRW{1'b0}},
  parameter int                    ILEN       = 32,
  parameter int                    DEPTH      = 4
)(
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  srst,
  input  logic                  enable,
  output logic                  inst_en,
  output logic [INST_ADDRW-1:0] inst_addr,
  input  logic [ILEN-1:0]       inst_rdata,
  input  logic                  inst_ready,
  input  logic                  flush_valid,
  input  logic [INST_ADDRW-1:0] flush_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ILEN-1:0]       instr_data,
  output logic [INST_ADDRW-1:0] instr_pc,
  output logic                  misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  typedef struct packed {
    logic [INST_ADDRW-1:0] pc;
    logic [ILEN-1:0]       data;
  } entry_t;

  state_t                state;
  logic [INST_ADDRW-1:0] pc;
  entry_t                mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  push, pop;
  logic [INST_ADDRW-1:0] pc_inc;
  entry_t                head;

  // A flush in the completion cycle drops that data, and a flush also cancels the pop.
  assign push    = (state == REQ) && inst_ready && !flush_valid;
  assign pop     = instr_valid && instr_ready && !flush_valid;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign pc_inc  = pc + INST_ADDRW'(4);

  assign head        = mem[rd_ptr];
  assign instr_valid = (cnt != '0);
  assign instr_data  = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc   : BOOT_ADDR;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= '{pc: inst_addr, data: inst_rdata};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      inst_en    <= 1'b0;
      inst_addr  <= BOOT_ADDR;
      pc         <= BOOT_ADDR;
      misaligned <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
    end else if (srst) begin
      state      <= IDLE;
      inst_en    <= 1'b0;
      inst_addr  <= BOOT_ADDR;
      pc         <= BOOT_ADDR;
      misaligned <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
    end else if (flush_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      pc         <= flush_addr;
      misaligned <= (flush_addr[1:0] != 2'b00);
      // inst_addr is left alone so a draining request keeps its address stable.
      if (state != IDLE && !inst_ready) begin
        state   <= DRAIN;
        inst_en <= 1'b1;
      end else begin
        state   <= IDLE;
        inst_en <= 1'b0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt_nxt;
      case (state)
        IDLE: begin
          if (enable && (cnt < DEPTH_C) && !misaligned) begin
            state     <= REQ;
            inst_en   <= 1'b1;
            inst_addr <= pc;
          end
        end
        REQ: begin
          if (inst_ready) begin
            pc <= pc_inc;
            // Only chain another request if the slot it will fill is free.
            if (enable && (cnt_nxt < DEPTH_C)) begin
              inst_addr <= pc_inc;
            end else begin
              state   <= IDLE;
              inst_en <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (inst_ready) begin
            state   <= IDLE;
            inst_en <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          inst_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_inst_prefetch.sv
// Bench for friscv_inst_prefetch: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the fetch/buffer rules.
module tb_friscv_inst_prefetch;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          srst = 1'b0;
  logic          enable = 1'b0;
  logic          inst_en;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_rdata;
  logic          inst_ready = 1'b0;
  logic          flush_valid = 1'b0;
  logic [AW-1:0] flush_addr = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_pc;
  logic          misaligned;

  always #5 aclk = ~aclk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'h5a5a, a};
  endfunction

  assign inst_rdata = mem_word(inst_addr);

  friscv_inst_prefetch #(
    .INST_ADDRW(AW), .BOOT_ADDR(16'h0000), .ILEN(32), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset), .srst(srst), .enable(enable),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ready(inst_ready), .flush_valid(flush_valid), .flush_addr(flush_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .misaligned(misaligned)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a request is either outstanding (busy) or not; dropped ones are flagged.
  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   data;
  } ent_t;

  ent_t          mq[$];
  bit            m_busy = 0, m_drop = 0, m_mis = 0;
  logic [AW-1:0] m_pc = '0, m_addr = '0;

  initial forever begin
    @(posedge aclk or posedge areset);
    if (areset || srst) begin
      mq.delete();
      m_busy = 0; m_drop = 0; m_mis = 0; m_pc = '0; m_addr = '0;
    end else if (flush_valid) begin
      mq.delete();
      m_pc   = flush_addr;
      m_mis  = (flush_addr[1:0] != 2'b00);
      m_busy = m_busy && !inst_ready;
      m_drop = m_busy;
    end else begin : upd
      bit start;
      start = !m_busy && enable && !m_mis && (mq.size() < DEPTH);
      if (instr_ready && mq.size() > 0) void'(mq.pop_front());
      if (m_busy && inst_ready) begin
        if (m_drop) begin
          m_busy = 0; m_drop = 0;
        end else begin
          mq.push_back('{m_addr, mem_word(m_addr)});
          m_pc   = m_addr + 16'd4;
          m_busy = enable && (mq.size() < DEPTH);
          m_addr = m_pc;
        end
      end
      if (start) begin
        m_busy = 1; m_addr = m_pc;
      end
    end
  end

  initial forever begin
    @(negedge aclk);
    if (!areset) begin
      chk("inst_en", 32'(inst_en), 32'(m_busy));
      if (m_busy) chk("inst_addr", 32'(inst_addr), 32'(m_addr));
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
        chk("instr_data", instr_data, mq[0].data);
      end
      chk("misaligned", 32'(misaligned), 32'(m_mis));
    end
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic wait_en(input string name, input logic [AW-1:0] exp);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (inst_en) begin
        seen = 1;
        chk(name, 32'(inst_addr), 32'(exp));
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic first_pc(input string name, input logic [AW-1:0] exp);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (instr_valid) begin
        seen = 1;
        chk(name, 32'(instr_pc), 32'(exp));
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_inst_en"}, 32'(inst_en), 32'd0);
    chk({tag, "_inst_addr"}, 32'(inst_addr), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr_data"}, instr_data, 32'd0);
    chk({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] pcs [6];
    int            cyc [6];
    logic [31:0]   d0;
    int            n, comps;

    // Reset state, then zero-wait streaming from BOOT_ADDR.
    repeat (2) tick();
    reset_vals("rst");
    enable = 1; inst_ready = 1; instr_ready = 1;
    tick();
    areset = 0;
    n = 0; d0 = '0;
    for (int j = 0; j < 6; j++) begin pcs[j] = 16'hffff; cyc[j] = 0; end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (instr_valid && n < 6) begin
        if (n == 0) d0 = instr_data;
        pcs[n] = instr_pc; cyc[n] = i; n++;
      end
    end
    for (int j = 0; j < 6; j++) chk("seq_pc", 32'(pcs[j]), 32'(j * 4));
    chk("back_to_back", 32'(cyc[5] - cyc[0]), 32'd5);
    chk("first_data", d0, 32'h5a5a0000);

    // Decode stalled: exactly DEPTH completions, then resume at 0x10.
    tick();
    instr_ready = 0; srst = 1;
    tick();
    srst = 0; comps = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (inst_en && inst_ready) comps++;
    end
    chk("stall_completions", 32'(comps), 32'd4);
    chk("stall_inst_en", 32'(inst_en), 32'd0);
    instr_ready = 1;
    wait_en("resume_addr", 16'h0010);

    // Wait-state memory, flush to 0x100 in the 2nd wait cycle.
    tick();
    inst_ready = 0; srst = 1;
    tick();
    srst = 0;
    wait_en("wait_first_addr", 16'h0000);
    tick();
    flush_valid = 1; flush_addr = 16'h0100;
    tick();
    flush_valid = 0;
    chk("drain_en", 32'(inst_en), 32'd1);
    chk("drain_addr", 32'(inst_addr), 32'd0);
    tick();
    inst_ready = 1;
    chk("drain_addr2", 32'(inst_addr), 32'd0);
    first_pc("flush_pc", 16'h0100);

    // Misaligned target blocks fetch until an aligned flush.
    tick();
    flush_valid = 1; flush_addr = 16'h0102;
    tick();
    flush_valid = 0;
    repeat (3) begin
      tick();
      chk("mis_flag", 32'(misaligned), 32'd1);
      chk("mis_no_fetch", 32'(inst_en), 32'd0);
    end
    flush_valid = 1; flush_addr = 16'h0200;
    tick();
    flush_valid = 0;
    chk("mis_cleared", 32'(misaligned), 32'd0);
    first_pc("aligned_pc", 16'h0200);

    // PC wraps modulo 2^16.
    tick();
    flush_valid = 1; flush_addr = 16'hfffc;
    tick();
    flush_valid = 0;
    first_pc("wrap_pre", 16'hfffc);
    tick();
    chk("wrap_valid", 32'(instr_valid), 32'd1);
    chk("wrap_pc", 32'(instr_pc), 32'd0);

    // Async reset mid-request with two buffered entries.
    tick();
    instr_ready = 0; inst_ready = 1; srst = 1;
    tick();
    srst = 0; comps = 0;
    for (int i = 0; i < 20 && comps < 2; i++) begin
      tick();
      if (inst_en) comps++;
    end
    tick();
    inst_ready = 0;
    tick();
    chk("pre_areset_valid", 32'(instr_valid), 32'd1);
    chk("pre_areset_en", 32'(inst_en), 32'd1);
    #2 areset = 1;
    #1 reset_vals("areset");
    tick();
    areset = 0; inst_ready = 1;
    wait_en("restart_addr", 16'h0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      enable      = ($urandom_range(0, 99) < 85);
      inst_ready  = ($urandom_range(0, 99) < 60);
      instr_ready = ($urandom_range(0, 99) < 70);
      srst        = ($urandom_range(0, 99) < 1);
      flush_valid = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 7))
        0:       flush_addr = AW'($urandom);
        1:       flush_addr = 16'hfff0 | AW'($urandom_range(0, 3) * 4);
        default: flush_addr = AW'($urandom) & 16'hfffc;
      endcase
    end
    tick();
    srst = 0; flush_valid = 0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
